// File: rtl/pio_in_edge_capture.sv
// Avalon-MM input PIO: synchronised, debounced inputs with sticky edge capture and maskable level irq.
// Latency: input change sampled at edge k is visible in the data register at edge k+1+Nd; reads are zero-wait-state.
// Backpressure: none; the slave never stalls, and writes and reads complete in the cycle they are presented.
module pio_in_edge_capture #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int ND = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int CW = $clog2(ND) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ND - 1);

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_CAP  = 3'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];
    logic             wr_strobe;
    logic             mask_we;
    logic             cap_we;
    logic             unused_wdata;

    assign wr_strobe    = chipselect & ~write_n;
    assign mask_we      = wr_strobe && (address == ADDR_MASK);
    assign cap_we       = wr_strobe && (address == ADDR_CAP);
    assign unused_wdata = ^writedata;

    // Any sample that returns to the stable level restarts the count, so a
    // pulse shorter than Nd cycles at sync2 can never be accepted.
    always_comb begin
        upd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (sync2[i] == stable[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                upd[i]     = 1'b1;
                cnt_nxt[i] = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + CW'(1);
            end
        end
    end

    assign stable_nxt = stable ^ upd;
    assign rise       = upd & sync2;
    assign fall       = upd & ~sync2;

    always_comb begin
        edge_set = upd;
        if (EDGE_TYPE == 0) begin
            edge_set = rise;
        end else if (EDGE_TYPE == 1) begin
            edge_set = fall;
        end
    end

    assign cap_clr = cap_we ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1        <= '0;
            sync2        <= '0;
            stable       <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1  <= in_port;
            sync2  <= sync1;
            stable <= stable_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            if (mask_we) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            // Set is applied after clear so a same-cycle edge survives the clear.
            edge_capture <= (edge_capture & ~cap_clr) | edge_set;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = stable;
            ADDR_MASK: readdata[WIDTH-1:0] = irq_mask;
            ADDR_CAP:  readdata[WIDTH-1:0] = edge_capture;
            default:   readdata = '0;
        endcase
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Bench for pio_in_edge_capture: rising, any-edge and falling builds driven from one shared bus,
// checked every cycle against a sliding-window model and at key points against literal values.
module tb_pio_in_edge_capture;

    localparam int ND = 4;
    localparam int HD = 8;
    localparam int ET [3] = '{0, 2, 1};

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_d [3];
    logic [2:0]  irq_d;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [7:0] stab_m = '0;
    logic [7:0] mask_m = '0;
    logic [7:0] cap_m  [3] = '{8'h0, 8'h0, 8'h0};
    logic [7:0] hist   [HD] = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};

    always #5 clk = ~clk;

    pio_in_edge_capture #(.WIDTH(8), .DEBOUNCE_CYCLES(ND), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_d[0]), .irq(irq_d[0]));

    pio_in_edge_capture #(.WIDTH(8), .DEBOUNCE_CYCLES(ND), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_d[1]), .irq(irq_d[1]));

    pio_in_edge_capture #(.WIDTH(8), .DEBOUNCE_CYCLES(ND), .EDGE_TYPE(1)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_d[2]), .irq(irq_d[2]));

    // A bit is accepted once the last ND values seen at the second synchroniser
    // stage (hist[1..ND]) all agree and differ from the current stable level.
    function automatic logic [7:0] win_stable(input logic [7:0] st, input logic [7:0] h [HD]);
        logic [7:0] r;
        r = st;
        for (int b = 0; b < 8; b++) begin
            bit agree;
            agree = 1'b1;
            for (int j = 1; j <= ND; j++) begin
                if (h[j][b] != h[1][b]) agree = 1'b0;
            end
            if (agree) r[b] = h[1][b];
        end
        return r;
    endfunction

    function automatic logic [7:0] edges(input int t, input logic [7:0] o, input logic [7:0] n);
        if (t == 0) return n & ~o;
        if (t == 1) return o & ~n;
        return o ^ n;
    endfunction

    function automatic logic [31:0] exp_rd(input int j);
        case (address)
            3'd0:    return {24'h0, stab_m};
            3'd2:    return {24'h0, mask_m};
            3'd3:    return {24'h0, cap_m[j]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!reset_n) begin
            stab_m <= '0;
            mask_m <= '0;
            for (int j = 0; j < 3; j++) cap_m[j] <= '0;
            for (int k = 0; k < HD; k++) hist[k] <= '0;
        end else begin
            stab_m <= win_stable(stab_m, hist);
            for (int j = 0; j < 3; j++) begin
                cap_m[j] <= (cap_m[j] & ~((chipselect && !write_n && address == 3'd3) ? writedata[7:0] : 8'h0))
                          | edges(ET[j], stab_m, win_stable(stab_m, hist));
            end
            if (chipselect && !write_n && address == 3'd2) mask_m <= writedata[7:0];
            hist[0] <= in_port;
            for (int k = 1; k < HD; k++) hist[k] <= hist[k-1];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("model_rd%0d", j), rd_d[j], exp_rd(j));
                chk($sformatf("model_irq%0d", j), {31'h0, irq_d[j]}, {31'h0, |(cap_m[j] & mask_m)});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
    endtask

    task automatic rdchk(input int inst, input logic [2:0] a, input logic [31:0] exp, input string name);
        address = a;
        @(negedge clk);
        chk(name, rd_d[inst], exp);
        @(posedge clk);
        #1;
        address = 3'd0;
    endtask

    task automatic irqchk(input int inst, input logic exp, input string name);
        @(negedge clk);
        chk(name, {31'h0, irq_d[inst]}, {31'h0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; in_port = 8'hFF; chipselect = 1'b0; write_n = 1'b1;
        address = 3'd0; writedata = '0;
        tick(3);
        in_port = 8'h00;
        tick(1);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick(4);

        rdchk(0, 3'd0, 32'h0, "rst_data");
        rdchk(0, 3'd2, 32'h0, "rst_mask");
        rdchk(0, 3'd3, 32'h0, "rst_cap");
        irqchk(0, 1'b0, "rst_irq");

        // Debounce latency and irq on an unmasked rising edge.
        wr(3'd2, 32'h01);
        in_port = 8'h01;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("lat_early", rd_d[0], 32'h00);
        chk("irq_early", {31'h0, irq_d[0]}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_exact", rd_d[0], 32'h01);
        chk("irq_set", {31'h0, irq_d[0]}, 32'h1);
        @(posedge clk);
        #1;
        rdchk(0, 3'd3, 32'h01, "cap_bit0");
        wr(3'd3, 32'h01);
        irqchk(0, 1'b0, "irq_clr");
        rdchk(0, 3'd3, 32'h00, "cap_clr");

        // Three-cycle glitch on bit1 must be filtered.
        in_port = 8'h03;
        tick(3);
        in_port = 8'h01;
        tick(10);
        rdchk(0, 3'd0, 32'h01, "glitch_data");
        rdchk(0, 3'd3, 32'h00, "glitch_cap");

        // Masked capture, then unmask a pending bit.
        wr(3'd2, 32'h00);
        in_port = 8'h09;
        tick(8);
        rdchk(0, 3'd3, 32'h08, "mask_cap");
        irqchk(0, 1'b0, "masked_irq");
        wr(3'd2, 32'h08);
        irqchk(0, 1'b1, "unmask_irq");
        wr(3'd3, 32'h08);
        irqchk(0, 1'b0, "unmask_clr");

        // Clear of bit2 lands on the same edge bit2 is accepted.
        in_port = 8'h0D;
        repeat (5) @(posedge clk);
        #1;
        chipselect = 1'b1; write_n = 1'b0; address = 3'd3; writedata = 32'h04;
        @(negedge clk);
        chk("coll_pre", rd_d[0], 32'h00);
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
        rdchk(0, 3'd3, 32'h04, "coll_set");
        rdchk(0, 3'd0, 32'h0D, "coll_data");

        // Edge-type variants.
        rdchk(2, 3'd3, 32'h00, "fall_none");
        in_port = 8'h2D;
        tick(8);
        rdchk(1, 3'd3, 32'h24, "any_rise");
        wr(3'd3, 32'h20);
        rdchk(1, 3'd3, 32'h04, "any_clr");
        in_port = 8'h0D;
        tick(8);
        rdchk(1, 3'd3, 32'h24, "any_fall");
        rdchk(2, 3'd3, 32'h20, "fall_cap");
        rdchk(0, 3'd3, 32'h04, "rise_nofall");

        // Reset mid-debounce with inputs high: pending change is dropped, then re-captured.
        in_port = 8'h0F;
        tick(2);
        chk_en  = 1'b0;
        reset_n = 1'b0;
        tick(2);
        rdchk(0, 3'd3, 32'h00, "rst_mid_cap");
        reset_n = 1'b1;
        tick(1);
        chk_en  = 1'b1;
        rdchk(0, 3'd0, 32'h00, "post_rst_early");
        tick(6);
        rdchk(0, 3'd0, 32'h0F, "post_rst_data");
        rdchk(0, 3'd3, 32'h0F, "post_rst_cap");
        rdchk(2, 3'd3, 32'h00, "post_rst_fall");

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
